enc_frame_sequencer: RTL and testbench

Frame sequencer and round-robin arbiter that shares the single 8b/10b encoder between NREQ byte-stream requesters. It wraps each granted frame in control symbols (SOF, EOF, ABORT) and drives the encoder's `pushin`/`datain`/`startin` inputs. It sits directly upstream of the encoder on the same `intf` clock domain.

---
 rtl/enc_seq_pkg.sv | 57 +++++
 rtl/enc_frame_sequencer_rr_arbiter.sv | 58 +++++
 rtl/enc_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_enc_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_seq_pkg.sv
// ---------------------------------------------------------------------------
// enc_seq_pkg
// Shared definitions for the 8b/10b frame sequencer:
//   - K-symbol constants placed on the encoder input (bit 8 = K flag)
//   - sequencer state enumeration
//   - encoder-side symbol bundle and the no-symbol filler
// Optional feature macro: ENC_SEQ_IDLE_FILL_EN
//   defined   -> no-symbol cycles push K28.5 (9'h1BC)
//   undefined -> no-symbol cycles push nothing (pushin=0, datain=0)
// ---------------------------------------------------------------------------
package enc_seq_pkg;

  localparam logic [8:0] K_SOF   = 9'h1FB;
  localparam logic [8:0] K_EOF   = 9'h1FD;
  localparam logic [8:0] K_ABORT = 9'h1FE;
  localparam logic [8:0] K_IDLE  = 9'h1BC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_EOF   = 3'd2,
    ST_ABORT = 3'd3,
    ST_DROP  = 3'd4
  } enc_seq_state_t;

  // One encoder-side symbol: push strobe, frame-start flag, 9-bit symbol.
  typedef struct packed {
    logic       push;
    logic       start;
    logic [8:0] data;
  } enc_sym_t;

  // What the encoder sees on a cycle that carries no frame symbol.
  function automatic enc_sym_t no_symbol();
    enc_sym_t s;
`ifdef ENC_SEQ_IDLE_FILL_EN
    s.push  = 1'b1;
    s.start = 1'b0;
    s.data  = K_IDLE;
`else
    s.push  = 1'b0;
    s.start = 1'b0;
    s.data  = 9'h000;
`endif
    return s;
  endfunction

  // A pushed frame symbol; start is only ever set together with SOF.
  function automatic enc_sym_t frame_symbol(input logic [8:0] data, input logic start);
    enc_sym_t s;
    s.push  = 1'b1;
    s.start = start;
    s.data  = data;
    return s;
  endfunction

endpackage

// File: rtl/enc_frame_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over NREQ requests. The search starts one position
// after the most recent grant; the pointer only moves when en is high, so
// the sequencer can hold a grant for a whole frame.
// Ports:
//   clk, reset (async, active-low)
//   req       [NREQ-1:0]          request vector
//   en                            commit the current pick to the pointer
//   grant     [NREQ-1:0]          one-hot pick (combinational)
//   grant_idx [$clog2(NREQ)-1:0]  encoded pick (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0] last_q;

  always_comb begin
    int            cand;
    logic [GW-1:0] cidx;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cidx = GW'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= GW'(NREQ - 1);
    end else if (en && (|req)) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/enc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// enc_frame_sequencer
// Shares one 8b/10b encoder between NREQ byte-stream requesters. A granted
// frame is wrapped as SOF, payload bytes, then EOF; a frame that reaches
// MAX_LEN bytes without its last flag is cut with ABORT and its remainder is
// drained silently. Encoder-side outputs are registered.
// Optional feature macro: ENC_SEQ_IDLE_FILL_EN (K28.5 fill on no-symbol cycles)
// Ports:
//   clk, reset      clock, async active-low reset
//   rq_valid/rq_data/rq_last/rq_ready   per-requester byte handshake
//                                       (requester i uses rq_data[8i+7:8i])
//   pushin, datain[8:0], startin        encoder input (datain[8] = K flag)
//   grant_id        current or most recent granted requester
//   busy            high outside IDLE
// ---------------------------------------------------------------------------
module enc_frame_sequencer
  import enc_seq_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAX_LEN = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         rq_valid,
  input  logic [NREQ*8-1:0]       rq_data,
  input  logic [NREQ-1:0]         rq_last,
  output logic [NREQ-1:0]         rq_ready,
  output logic                    pushin,
  output logic [8:0]              datain,
  output logic                    startin,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] LEN_LIMIT = CW'(MAX_LEN);

  enc_seq_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, cnt_inc;
  logic [NREQ-1:0] grant_oh;
  enc_sym_t       sym_nxt;

  logic [NREQ-1:0] arb_gnt;
  logic [GW-1:0]   arb_idx;
  logic            arb_en;

  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  // A new grant is only taken from IDLE; it is then held for the whole frame.
  assign arb_en = (state == ST_IDLE) && (|rq_valid);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (rq_valid),
    .en        (arb_en),
    .grant     (arb_gnt),
    .grant_idx (arb_idx)
  );

  // Granted requester's lane, picked through the registered one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_valid = rq_valid[i];
        sel_last  = rq_last[i];
        sel_data  = rq_data[i*8 +: 8];
      end
    end
  end

  assign rq_ready = ((state == ST_DATA) || (state == ST_DROP)) ? grant_oh : '0;
  assign busy     = (state != ST_IDLE);
  assign cnt_inc  = cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sym_nxt   = no_symbol();
    case (state)
      ST_IDLE: begin
        if (|rq_valid) begin
          state_nxt = ST_DATA;
          cnt_nxt   = '0;
          sym_nxt   = frame_symbol(K_SOF, 1'b1);
        end
      end
      ST_DATA: begin
        if (sel_valid) begin
          cnt_nxt = cnt_inc;
          sym_nxt = frame_symbol({1'b0, sel_data}, 1'b0);
          // last wins over the length limit: an exact-length frame ends cleanly
          if (sel_last) begin
            state_nxt = ST_EOF;
          end else if (cnt_inc == LEN_LIMIT) begin
            state_nxt = ST_ABORT;
          end
        end
      end
      ST_EOF: begin
        sym_nxt   = frame_symbol(K_EOF, 1'b0);
        state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        sym_nxt   = frame_symbol(K_ABORT, 1'b0);
        state_nxt = ST_DROP;
      end
      ST_DROP: begin
        // remainder of an over-length frame is accepted and discarded
        if (sel_valid && sel_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- registered control and encoder-side outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      grant_id <= '0;
      grant_oh <= '0;
      pushin   <= 1'b0;
      startin  <= 1'b0;
      datain   <= 9'h000;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pushin  <= sym_nxt.push;
      startin <= sym_nxt.start;
      datain  <= sym_nxt.data;
      if (arb_en) begin
        grant_id <= arb_idx;
        grant_oh <= arb_gnt;
      end
    end
  end

endmodule

// File: tb/tb_enc_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_enc_frame_sequencer
// Directed bench for enc_frame_sequencer (NREQ=2, MAX_LEN=4). Requesters are
// byte queues ({last, byte}) that hold data until accepted. Expected symbols
// are written per cycle as {pushin, startin, datain}. No-symbol cycles follow
// ENC_SEQ_IDLE_FILL_EN.
// ---------------------------------------------------------------------------
module tb_enc_frame_sequencer;

  localparam int NREQ    = 2;
  localparam int MAX_LEN = 4;

  localparam logic [10:0] SOF_E = {1'b1, 1'b1, 9'h1FB};
  localparam logic [10:0] EOF_E = {1'b1, 1'b0, 9'h1FD};
  localparam logic [10:0] ABT_E = {1'b1, 1'b0, 9'h1FE};
`ifdef ENC_SEQ_IDLE_FILL_EN
  localparam logic [10:0] NS_E  = {1'b1, 1'b0, 9'h1BC};
`else
  localparam logic [10:0] NS_E  = 11'h000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   rq_valid;
  logic [NREQ*8-1:0] rq_data;
  logic [NREQ-1:0]   rq_last;
  logic [NREQ-1:0]   rq_ready;
  logic              pushin;
  logic [8:0]        datain;
  logic              startin;
  logic              grant_id;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       gap0 = 1'b0;

  always #5 clk = ~clk;

  enc_frame_sequencer #(
    .NREQ    (NREQ),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rq_valid (rq_valid),
    .rq_data  (rq_data),
    .rq_last  (rq_last),
    .rq_ready (rq_ready),
    .pushin   (pushin),
    .datain   (datain),
    .startin  (startin),
    .grant_id (grant_id),
    .busy     (busy)
  );

  function automatic logic [10:0] dat(input logic [7:0] b);
    return {1'b1, 1'b0, 1'b0, b};
  endfunction

  task automatic drive_inputs();
    rq_valid[0]  = (q0.size() > 0) && !gap0;
    rq_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    rq_last[0]   = (q0.size() > 0) ? q0[0][8] : 1'b0;
    rq_valid[1]  = (q1.size() > 0);
    rq_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
    rq_last[1]   = (q1.size() > 0) ? q1[0][8] : 1'b0;
  endtask

  // Advance one cycle: bytes handshaken in this cycle leave their queues.
  task automatic tick();
    logic a0, a1;
    a0 = rq_valid[0] & rq_ready[0];
    a1 = rq_valid[1] & rq_ready[1];
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive_inputs();
  endtask

  // Leaves the DUT just out of reset, 1 time unit after a rising edge.
  task automatic reset_dut();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    gap0 = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    q0.delete();
    q1.delete();
    q0.push_back(9'h1AA);
    q1.push_back(9'h1BB);
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({pushin, startin, datain} !== 11'h000) $display("FAIL reset_sym: got %h want 000", {pushin, startin, datain});
    else n_pass++;
    n_total++;
    if (rq_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", rq_ready);
    else n_pass++;
    n_total++;
    if ({busy, grant_id} !== 2'b00) $display("FAIL reset_busy_gid: got %b want 00", {busy, grant_id});
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    logic [10:0] exp [1:6];
    reset_dut();
    exp = '{SOF_E, dat(8'hA1), dat(8'hA2), dat(8'hA3), EOF_E, NS_E};
    q0.push_back(9'h0A1);
    q0.push_back(9'h0A2);
    q0.push_back(9'h1A3);
    drive_inputs();
    n_total++;
    if (busy !== 1'b0 || rq_ready !== 2'b00) $display("FAIL basic_c0: got busy=%b ready=%b want 0/00", busy, rq_ready);
    else n_pass++;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL basic_sym c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
      n_total++;
      if (rq_ready !== ((c <= 3) ? 2'b01 : 2'b00)) $display("FAIL basic_ready c%0d: got %b", c, rq_ready);
      else n_pass++;
      n_total++;
      if (busy !== (c <= 4)) $display("FAIL basic_busy c%0d: got %b want %b", c, busy, (c <= 4));
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    logic [10:0] exp [1:17];
    reset_dut();
    exp = '{SOF_E, dat(8'h10), dat(8'h11), EOF_E,
            SOF_E, dat(8'h20), dat(8'h21), EOF_E,
            SOF_E, dat(8'h12), dat(8'h13), EOF_E,
            SOF_E, dat(8'h22), dat(8'h23), EOF_E, NS_E};
    q0 = '{9'h010, 9'h111, 9'h012, 9'h113};
    q1 = '{9'h020, 9'h121, 9'h022, 9'h123};
    drive_inputs();
    for (int c = 1; c <= 17; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL fair_sym c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        n_total++;
        if (grant_id !== ((c == 5 || c == 13) ? 1'b1 : 1'b0)) $display("FAIL fair_gid c%0d: got %b", c, grant_id);
        else n_pass++;
        n_total++;
        if (rq_ready !== ((c == 5 || c == 13) ? 2'b10 : 2'b01)) $display("FAIL fair_ready c%0d: got %b", c, rq_ready);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overlength();
    logic [10:0] exp [1:9];
    reset_dut();
    exp = '{SOF_E, dat(8'h31), dat(8'h32), dat(8'h33), dat(8'h34), ABT_E, NS_E, NS_E, NS_E};
    q0 = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h136};
    drive_inputs();
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL over_sym c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
      if (c >= 5 && c <= 8) begin
        n_total++;
        if (rq_ready !== ((c == 6 || c == 7) ? 2'b01 : 2'b00)) $display("FAIL over_ready c%0d: got %b", c, rq_ready);
        else n_pass++;
        n_total++;
        if (busy !== (c <= 7)) $display("FAIL over_busy c%0d: got %b", c, busy);
        else n_pass++;
      end
    end
    n_total++;
    if (q0.size() != 0) $display("FAIL over_drained: got %0d bytes left want 0", q0.size());
    else n_pass++;
  endtask

  task automatic test_exact_length();
    logic [10:0] exp [1:7];
    reset_dut();
    exp = '{SOF_E, dat(8'h41), dat(8'h42), dat(8'h43), dat(8'h44), EOF_E, NS_E};
    q0 = '{9'h041, 9'h042, 9'h043, 9'h144};
    drive_inputs();
    for (int c = 1; c <= 7; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL exact_sym c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
      if (c == 6) begin
        n_total++;
        if (busy !== 1'b0) $display("FAIL exact_busy c6: got %b want 0", busy);
        else n_pass++;
      end
    end
  endtask

  task automatic test_gap_fill();
    logic [10:0] exp [1:7];
    reset_dut();
    exp = '{SOF_E, dat(8'h51), NS_E, dat(8'h52), dat(8'h53), EOF_E, NS_E};
    q0 = '{9'h051, 9'h052, 9'h153};
    drive_inputs();
    for (int c = 1; c <= 7; c++) begin
      gap0 = (c == 2);
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL gap_sym c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
    end
    gap0 = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] exp [1:4];
    reset_dut();
    q0 = '{9'h061, 9'h062, 9'h063, 9'h164};
    drive_inputs();
    exp = '{SOF_E, dat(8'h61), dat(8'h62), NS_E};
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL midrst_pre c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
    end
    reset = 1'b0;
    #1;
    n_total++;
    if ({pushin, startin, datain, busy, rq_ready} !== 14'h0) $display("FAIL midrst_clear: got sym=%h busy=%b ready=%b want 0", {pushin, startin, datain}, busy, rq_ready);
    else n_pass++;
    q0.delete();
    q0.push_back(9'h171);
    q1.push_back(9'h181);
    drive_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp = '{SOF_E, dat(8'h71), EOF_E, SOF_E};
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_total++;
      if ({pushin, startin, datain} !== exp[c]) $display("FAIL midrst_post c%0d: got %h want %h", c, {pushin, startin, datain}, exp[c]);
      else n_pass++;
      if (c == 1 || c == 4) begin
        n_total++;
        if (grant_id !== (c == 4)) $display("FAIL midrst_gid c%0d: got %b want %b", c, grant_id, (c == 4));
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    rq_valid = '0;
    rq_data  = '0;
    rq_last  = '0;
    test_reset();
    test_basic_frame();
    test_fairness();
    test_overlength();
    test_exact_length();
    test_gap_fill();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
